// File: rtl/hwpe_stream_package.sv
// Shared types for the hwpe stream blocks: demux switch FSM encoding and
// destination select constants.
package hwpe_stream_package;

  // Switch FSM: PASS streams normally, DRAIN empties the held beat before
  // the committed destination is allowed to change.
  typedef enum logic [0:0] {
    PASS  = 1'b0,
    DRAIN = 1'b1
  } demux_state_e;

  localparam logic SEL_POP_0 = 1'b0;
  localparam logic SEL_POP_1 = 1'b1;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle with data and byte strobe.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_demux_registered.sv
// 1-to-2 stream demultiplexer with one registered output stage.
// The held beat always goes to the destination committed when it was
// accepted; a destination change waits (DRAIN) until that beat has left.
module hwpe_stream_demux_registered
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   sel_i,
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_0_o,
  hwpe_stream_intf_stream.source pop_1_o,
  output logic                   sel_q_o,
  output logic                   busy_o
);

  demux_state_e          state_q, state_d;
  logic                  sel_q, sel_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;

  logic                  rst_any_s;
  logic                  sel_pop_ready_s;
  logic                  push_ready_s;
  logic                  push_hs_s;
  logic                  pop_hs_s;
  logic                  pop0_valid_s, pop1_valid_s;
  logic [DATA_WIDTH-1:0] pop0_data_s, pop1_data_s;
  logic [STRB_WIDTH-1:0] pop0_strb_s, pop1_strb_s;
  logic                  sel_q_out_s, busy_out_s;

  // rst_i and clear_i act identically; asserting both is just one reset.
  assign rst_any_s = rst_i | clear_i;

  // FSM state and committed destination register.
  always_ff @(posedge clk_i) begin
    if (rst_any_s) begin
      state_q <= PASS;
      sel_q   <= SEL_POP_0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // FSM next state: commit a new destination only once nothing is held.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      PASS: begin
        if (sel_i != sel_q) begin
          if (valid_q) begin
            state_d = DRAIN;
          end else begin
            state_d = PASS;
            sel_d   = sel_i;
          end
        end else begin
          state_d = PASS;
        end
      end
      DRAIN: begin
        // sel_i may have returned to sel_q meanwhile; then sel_d keeps it.
        if (!valid_q || pop_hs_s) begin
          state_d = PASS;
          sel_d   = sel_i;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = PASS;
        sel_d   = sel_q;
      end
    endcase
  end

  // FSM outputs: handshakes, routing of the held beat and status.
  always_comb begin
    sel_pop_ready_s = (sel_q == SEL_POP_1) ? pop_1_o.ready : pop_0_o.ready;
    pop_hs_s        = 1'b0;
    push_ready_s    = 1'b0;
    pop0_valid_s    = 1'b0;
    pop1_valid_s    = 1'b0;
    pop0_data_s     = {DATA_WIDTH{1'b0}};
    pop1_data_s     = {DATA_WIDTH{1'b0}};
    pop0_strb_s     = {STRB_WIDTH{1'b0}};
    pop1_strb_s     = {STRB_WIDTH{1'b0}};
    sel_q_out_s     = 1'b0;
    busy_out_s      = 1'b0;
    if (rst_any_s) begin
      pop_hs_s     = 1'b0;
      push_ready_s = 1'b0;
    end else begin
      pop_hs_s     = valid_q & sel_pop_ready_s;
      push_ready_s = (state_q == PASS) & (sel_i == sel_q) &
                     (~valid_q | sel_pop_ready_s);
      sel_q_out_s  = sel_q;
      busy_out_s   = valid_q | (state_q == DRAIN);
      if (sel_q == SEL_POP_1) begin
        pop1_valid_s = valid_q;
        pop1_data_s  = data_q;
        pop1_strb_s  = strb_q;
      end else begin
        pop0_valid_s = valid_q;
        pop0_data_s  = data_q;
        pop0_strb_s  = strb_q;
      end
    end
  end

  assign push_hs_s = push_i.valid & push_ready_s;

  // Output stage next value: a new beat replaces a leaving one in the same cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    strb_d  = strb_q;
    if (push_hs_s) begin
      valid_d = 1'b1;
      data_d  = push_i.data;
      strb_d  = push_i.strb;
    end else if (pop_hs_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output stage register; reset drops a held beat without a handshake.
  always_ff @(posedge clk_i) begin
    if (rst_any_s) begin
      valid_q <= 1'b0;
      data_q  <= {DATA_WIDTH{1'b0}};
      strb_q  <= {STRB_WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
    end
  end

  assign push_i.ready  = push_ready_s;
  assign pop_0_o.valid = pop0_valid_s;
  assign pop_0_o.data  = pop0_data_s;
  assign pop_0_o.strb  = pop0_strb_s;
  assign pop_1_o.valid = pop1_valid_s;
  assign pop_1_o.data  = pop1_data_s;
  assign pop_1_o.strb  = pop1_strb_s;
  assign sel_q_o       = sel_q_out_s;
  assign busy_o        = busy_out_s;

endmodule

// File: tb/tb_hwpe_stream_demux_registered.sv
// Bench for hwpe_stream_demux_registered: directed scenarios plus a random
// run, all checked against a transaction-level reference model.
module tb_hwpe_stream_demux_registered;

  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst, clear, sel;
  logic sel_q, busy;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop0 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop1 ();

  hwpe_stream_demux_registered #(.DATA_WIDTH(DW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clear),
    .sel_i   (sel),
    .push_i  (push),
    .pop_0_o (pop0),
    .pop_1_o (pop1),
    .sel_q_o (sel_q),
    .busy_o  (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a slot holding at most one beat tagged with its
  // destination, a committed destination and a pending-switch flag.
  typedef struct packed {
    logic          dest;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } beat_t;

  beat_t slot[$];
  beat_t exp0[$];
  beat_t exp1[$];
  logic  m_sel   = 1'b0;
  logic  m_drain = 1'b0;

  task automatic model_step();
    beat_t head, b, got;
    logic  full, rdy, e_ready, popped;
    if (rst || clear) begin
      check("rst_ready", push.ready, 1'b0);
      check("rst_v0", pop0.valid, 1'b0);
      check("rst_v1", pop1.valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_selq", sel_q, 1'b0);
      if (slot.size() != 0) begin
        if (slot[0].dest) void'(exp1.pop_back());
        else void'(exp0.pop_back());
        slot.delete();
      end
      m_sel   = 1'b0;
      m_drain = 1'b0;
    end else begin
      full = (slot.size() != 0);
      head = full ? slot[0] : '0;
      rdy  = m_sel ? pop1.ready : pop0.ready;
      e_ready = !m_drain && (sel == m_sel) && (!full || rdy);
      check("m_ready", push.ready, e_ready);
      check("m_v0", pop0.valid, full && !head.dest);
      check("m_v1", pop1.valid, full && head.dest);
      check("m_busy", busy, full || m_drain);
      check("m_selq", sel_q, m_sel);
      if (full) begin
        check("m_data", head.dest ? pop1.data : pop0.data, head.data);
        check("m_strb", head.dest ? pop1.strb : pop0.strb, head.strb);
      end
      if (m_sel) begin
        check("m_idle_d0", {pop0.strb, pop0.data}, 36'h0);
      end else begin
        check("m_idle_d1", {pop1.strb, pop1.data}, 36'h0);
      end
      // scoreboard on observed handshakes: per-destination order, no loss/dup
      if (pop0.valid && pop0.ready) begin
        check("sb0_nonempty", exp0.size() != 0, 1'b1);
        if (exp0.size() != 0) begin
          got = exp0.pop_front();
          check("sb0_data", pop0.data, got.data);
        end
      end
      if (pop1.valid && pop1.ready) begin
        check("sb1_nonempty", exp1.size() != 0, 1'b1);
        if (exp1.size() != 0) begin
          got = exp1.pop_front();
          check("sb1_data", pop1.data, got.data);
        end
      end
      popped = full && rdy;
      if (popped) void'(slot.pop_front());
      if (push.valid && e_ready) begin
        b.dest = m_sel;
        b.data = push.data;
        b.strb = push.strb;
        slot.push_back(b);
        if (m_sel) exp1.push_back(b);
        else exp0.push_back(b);
      end
      if (m_drain) begin
        if (!full || popped) begin
          m_sel   = sel;
          m_drain = 1'b0;
        end
      end else if (sel != m_sel) begin
        if (!full) m_sel = sel;
        else m_drain = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int hs;
    rst = 1'b1; clear = 1'b0; sel = 1'b0;
    push.valid = 1'b0; push.data = '0; push.strb = '0;
    pop0.ready = 1'b0; pop1.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_selq", sel_q, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_v0", pop0.valid, 1'b0);
    nc();

    // streaming on pop_0
    pop0.ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        push.valid = 1'b1; push.data = 32'h11 + 32'(i); push.strb = 4'hF;
      end else begin
        push.valid = 1'b0;
      end
      @(negedge clk);
      if (i < 8) check("stream_ready", push.ready, 1'b1);
      if (i > 0) begin
        check("stream_v0", pop0.valid, 1'b1);
        check("stream_d0", pop0.data, 32'h11 + 32'(i) - 32'd1);
      end
      check("stream_v1", pop1.valid, 1'b0);
      nc();
    end

    // backpressure on pop_1
    sel = 1'b1; @(negedge clk); nc();
    push.valid = 1'b1; push.data = 32'hA5; pop1.ready = 1'b0; hs = 0;
    @(negedge clk); check("bp_accept", push.ready, 1'b1); nc();
    push.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_v1", pop1.valid, 1'b1);
      check("bp_d1", pop1.data, 32'hA5);
      check("bp_ready", push.ready, 1'b0);
      if (pop1.valid && pop1.ready) hs++;
      nc();
    end
    pop1.ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (pop1.valid && pop1.ready) hs++;
      nc();
    end
    check("bp_handshakes", hs, 1);

    // switch while a beat is held
    sel = 1'b0; @(negedge clk); nc();
    pop0.ready = 1'b0; push.valid = 1'b1; push.data = 32'hC0;
    @(negedge clk); check("sw_accept", push.ready, 1'b1); nc();
    push.valid = 1'b0; sel = 1'b1;
    @(negedge clk); check("sw_v0", pop0.valid, 1'b1); check("sw_ready", push.ready, 1'b0); nc();
    @(negedge clk);
    check("sw_busy_drain", busy, 1'b1);
    check("sw_selq_hold", sel_q, 1'b0);
    check("sw_d0", pop0.data, 32'hC0);
    nc();
    pop0.ready = 1'b1;
    @(negedge clk); check("sw_v0_release", pop0.valid, 1'b1); check("sw_d0_release", pop0.data, 32'hC0); nc();
    push.valid = 1'b1; push.data = 32'hC1; pop1.ready = 1'b1;
    @(negedge clk);
    check("sw_selq_new", sel_q, 1'b1);
    check("sw_v0_gone", pop0.valid, 1'b0);
    check("sw_ready1", push.ready, 1'b1);
    nc();
    push.valid = 1'b0;
    @(negedge clk); check("sw_v1", pop1.valid, 1'b1); check("sw_d1", pop1.data, 32'hC1); nc();

    // idle switch
    sel = 1'b0; @(negedge clk); nc();
    sel = 1'b1;
    @(negedge clk);
    check("idle_selq_before", sel_q, 1'b0);
    check("idle_v0", pop0.valid, 1'b0);
    check("idle_v1", pop1.valid, 1'b0);
    nc();
    @(negedge clk);
    check("idle_selq_after", sel_q, 1'b1);
    check("idle_v1_after", pop1.valid, 1'b0);
    nc();

    // reset with a held beat
    sel = 1'b0; @(negedge clk); nc();
    pop0.ready = 1'b0; push.valid = 1'b1; push.data = 32'h5A;
    @(negedge clk); nc();
    push.valid = 1'b0;
    @(negedge clk); check("mr_v0_held", pop0.valid, 1'b1); check("mr_d0_held", pop0.data, 32'h5A); nc();
    rst = 1'b1;
    @(negedge clk); check("mr_v0_in_rst", pop0.valid, 1'b0); check("mr_busy_in_rst", busy, 1'b0); nc();
    rst = 1'b0; pop0.ready = 1'b1; hs = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (pop0.valid && pop0.ready && pop0.data == 32'h5A) hs++;
      check("mr_v0_after", pop0.valid, 1'b0);
      check("mr_selq_after", sel_q, 1'b0);
      nc();
    end
    check("mr_5a_handshakes", hs, 0);

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      push.valid = ($urandom_range(0, 2) != 0);
      push.data  = $urandom;
      push.strb  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) sel = ~sel;
      pop0.ready = ($urandom_range(0, 9) < 7);
      pop1.ready = ($urandom_range(0, 9) < 7);
      clear      = ($urandom_range(0, 99) == 0);
      nc();
    end
    clear = 1'b0; push.valid = 1'b0; pop0.ready = 1'b1; pop1.ready = 1'b1;
    repeat (5) nc();
    @(negedge clk);
    check("end_q0_empty", exp0.size(), 0);
    check("end_q1_empty", exp1.size(), 0);
    check("end_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_demux_registered.md
HWPE_STREAM_DEMUX_REGISTERED -- requirements
Module: hwpe_stream_demux_registered

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of stream data.
REQ-002 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, width of stream strobe.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port clear_i, input, 1, synchronous soft clear, same effect as rst_i.
REQ-006 SHALL have port sel_i, input, 1, requested destination: 0 selects pop_0_o, 1 selects pop_1_o.
REQ-007 SHALL have port push_i, hwpe_stream_intf_stream.sink, DATA_WIDTH, input stream.
REQ-008 SHALL have port pop_0_o, hwpe_stream_intf_stream.source, DATA_WIDTH, output stream 0.
REQ-009 SHALL have port pop_1_o, hwpe_stream_intf_stream.source, DATA_WIDTH, output stream 1.
REQ-010 SHALL have port sel_q_o, output, 1, currently committed destination.
REQ-011 SHALL have port busy_o, output, 1, high while a beat is held or a switch is draining.

Function
REQ-012 SHALL hold one output register stage (valid_q, data_q, strb_q), routed only to the destination given by sel_q.
REQ-013 SHALL drive the non-selected pop valid to 0, its data and strb to 0.
REQ-014 SHALL accept a push beat when push_i.valid and push_i.ready are both 1.
REQ-015 SHALL present an accepted beat on the selected pop exactly 1 cycle after acceptance.
REQ-016 SHALL drive push_i.ready = (state==PASS) and (sel_i==sel_q) and (!valid_q or selected pop ready).
REQ-017 SHALL sustain 1 beat/cycle when sel_i is constant and the selected sink is always ready.
REQ-018 SHALL keep valid_q, data_q and strb_q stable while valid_q=1 and the selected pop ready=0.
REQ-019 SHALL clear valid_q on a pop handshake with no simultaneous push handshake; on simultaneous pop and push, SHALL load the new beat with valid_q=1.
REQ-020 SHALL implement FSM states PASS and DRAIN.
REQ-021 PASS: if sel_i != sel_q and valid_q=0, SHALL set sel_q=sel_i next cycle and remain in PASS.
REQ-022 PASS: if sel_i != sel_q and valid_q=1, SHALL go to DRAIN; push_i.ready=0.
REQ-023 DRAIN: SHALL hold push_i.ready=0; on the pop handshake emptying valid_q, SHALL set sel_q=sel_i and return to PASS.
REQ-024 DRAIN: if sel_i returns to the value of sel_q, SHALL still complete the drain, then return to PASS with sel_q unchanged.
REQ-025 SHALL never route a beat to a destination other than the sel_q value at its acceptance; no beat lost or duplicated across a switch.
REQ-026 SHALL drive busy_o = valid_q or (state==DRAIN); sel_q_o = sel_q.
REQ-027 clear_i or rst_i asserted mid-transfer SHALL drop any held beat without a pop handshake.

Reset
REQ-028 On rst_i=1 or clear_i=1, SHALL set state=PASS, sel_q=0, valid_q=0, data_q=0, strb_q=0.
REQ-029 During reset, SHALL drive all pop valid=0, push_i.ready=0, busy_o=0, sel_q_o=0.
REQ-030 If both rst_i and clear_i are asserted, SHALL behave as a single reset.

Structure
REQ-031 The FSM state enum (PASS, DRAIN) SHALL reside in hwpe_stream_package.
REQ-032 Single module, no sub-modules; the output register is inline.

Verification
REQ-033 Streaming: sel_i=0, push beats 0x11..0x18 back-to-back, pop_0 always ready -> 8 beats on pop_0 at 1 beat/cycle, 1-cycle latency, pop_1 valid never 1.
REQ-034 Backpressure: sel_i=1, push 0xA5, pop_1 ready low 3 cycles -> data 0xA5 held stable on pop_1, push_i.ready=0, exactly one handshake.
REQ-035 Switch with beat held: push 0xC0 to out 0 with pop_0 stalled, then sel_i=1 -> DRAIN, busy_o=1; release pop_0 -> 0xC0 on pop_0, sel_q_o=1 next cycle, next beat 0xC1 on pop_1.
REQ-036 Idle switch: valid_q=0, toggle sel_i 0->1 -> sel_q_o=1 after 1 cycle, no pop valid pulses.
REQ-037 Mid-transfer reset: beat 0x5A held, pop_0 stalled, assert rst_i one cycle -> valid_q=0, sel_q_o=0, 0x5A never handshaken.
REQ-038 Random: random valid/ready/sel_i for 10k cycles -> scoreboard shows per-destination in-order delivery, no loss or duplication.
